// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

   localparam int unsigned NumStagesDef = 8;
   localparam int unsigned AddrWDef     = 32;

   // Exception-redirect sequencer states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFlush = 2'd1,
      StRedir = 2'd2
   } state_e;

   // Inter-stage register stall pair {stall[k], stall[k+1]}
   localparam logic [1:0] PairAdvance = 2'b00;
   localparam logic [1:0] PairBubble  = 2'b10;
   localparam logic [1:0] PairHold    = 2'b11;

   // Width of the packed stall bus: one pair per inter-stage register
   function automatic int unsigned stall_bus_w(input int unsigned num_stages);
      return 2 * (num_stages - 1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline and pipe_ctrl.
// Optional perf counters appear when PIPE_CTRL_PERF_CNT_EN is defined.
interface pipe_ctrl_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NumStagesDef,
   parameter int unsigned ADDR_W     = AddrWDef
) ();

   logic [NUM_STAGES-1:0]                  stallreq;
   logic                                   except_req;
   logic [ADDR_W-1:0]                      except_target;
   logic                                   fetch_ready;
   logic [NUM_STAGES-1:0]                  stall_vec;
   logic [stall_bus_w(NUM_STAGES)-1:0]     stall_bus;
   logic                                   flush;
   logic                                   redirect_valid;
   logic [ADDR_W-1:0]                      redirect_pc;
   logic                                   busy;
`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0]                            stall_cycles;
   logic [31:0]                            flush_count;
`endif

   // Controller side
   modport master (
      input  stallreq, except_req, except_target, fetch_ready,
`ifdef PIPE_CTRL_PERF_CNT_EN
      output stall_cycles, flush_count,
`endif
      output stall_vec, stall_bus, flush, redirect_valid, redirect_pc, busy
   );

   // Pipeline side
   modport slave (
      output stallreq, except_req, except_target, fetch_ready,
`ifdef PIPE_CTRL_PERF_CNT_EN
      input  stall_cycles, flush_count,
`endif
      input  stall_vec, stall_bus, flush, redirect_valid, redirect_pc, busy
   );

endinterface

// File: rtl/pipe_stall_resolve.sv
// Suffix-OR stall resolution and per-register stall pair packing.
module pipe_stall_resolve
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NumStagesDef
) (
   input  logic [NUM_STAGES-1:0]              stallreq_i,
   input  logic                               force_zero_i,
   input  logic                               force_fetch_i,
   output logic [NUM_STAGES-1:0]              stall_vec_o,
   output logic [stall_bus_w(NUM_STAGES)-1:0] stall_bus_o
);

   logic acc;

   // An older stall freezes every younger stage; flush beats everything
   always_comb begin
      acc         = 1'b0;
      stall_vec_o = '0;
      for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
         acc            = acc | stallreq_i[i];
         stall_vec_o[i] = acc;
      end
      if (force_zero_i) begin
         stall_vec_o = '0;
      end else if (force_fetch_i) begin
         stall_vec_o[0] = 1'b1;
      end
   end

   // The vector is monotone (never {0,1}), so this equals {vec[k], vec[k+1]}
   always_comb begin
      stall_bus_o = '0;
      for (int k = 0; k < int'(NUM_STAGES) - 1; k++) begin
         if (!stall_vec_o[k]) begin
            stall_bus_o[2*k +: 2] = PairAdvance;
         end else if (stall_vec_o[k+1]) begin
            stall_bus_o[2*k +: 2] = PairHold;
         end else begin
            stall_bus_o[2*k +: 2] = PairBubble;
         end
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: resolves stage stalls and sequences
// exception redirection (flush pulse, then held redirect PC until fetch
// accepts). Define PIPE_CTRL_PERF_CNT_EN to add stall/flush counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned NUM_STAGES = NumStagesDef,
   parameter int unsigned ADDR_W     = AddrWDef
) (
   input logic       clk,
   input logic       reset,
   pipe_ctrl_if.master bus
);

   state_e            state_q;
   logic              flush_q;
   logic              redirect_valid_q;
   logic              busy_q;
   logic [ADDR_W-1:0] redirect_pc_q;
   logic [NUM_STAGES-1:0] stall_vec;

   // Redirect sequencer; the newest exception always restarts the flush
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StIdle;
         flush_q          <= 1'b0;
         redirect_valid_q <= 1'b0;
         busy_q           <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.except_req) begin
                  state_q          <= StFlush;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  busy_q           <= 1'b1;
                  redirect_pc_q    <= bus.except_target;
               end
            end
            StFlush, StRedir: begin
               if (bus.except_req) begin
                  state_q          <= StFlush;
                  flush_q          <= 1'b1;
                  redirect_valid_q <= 1'b1;
                  busy_q           <= 1'b1;
                  redirect_pc_q    <= bus.except_target;
               end else if (bus.fetch_ready) begin
                  state_q          <= StIdle;
                  flush_q          <= 1'b0;
                  redirect_valid_q <= 1'b0;
                  busy_q           <= 1'b0;
               end else begin
                  state_q          <= StRedir;
                  flush_q          <= 1'b0;
                  redirect_valid_q <= 1'b1;
                  busy_q           <= 1'b1;
               end
            end
            default: begin
               state_q          <= StIdle;
               flush_q          <= 1'b0;
               redirect_valid_q <= 1'b0;
               busy_q           <= 1'b0;
            end
         endcase
      end
   end

   // Holding stage 0 in REDIR stops the PC from self-incrementing
   pipe_stall_resolve #(
      .NUM_STAGES (NUM_STAGES)
   ) u_stall_resolve (
      .stallreq_i    (bus.stallreq),
      .force_zero_i  (flush_q),
      .force_fetch_i (state_q == StRedir),
      .stall_vec_o   (stall_vec),
      .stall_bus_o   (bus.stall_bus)
   );

   assign bus.stall_vec      = stall_vec;
   assign bus.flush          = flush_q;
   assign bus.redirect_valid = redirect_valid_q;
   assign bus.redirect_pc    = redirect_pc_q;
   assign bus.busy           = busy_q;

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] stall_cycles_q;
   logic [31:0] flush_count_q;

   // Free-running wrap-around perf counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (stall_vec[0] && !flush_q) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (flush_q) begin
            flush_count_q <= flush_count_q + 32'd1;
         end
      end
   end

   assign bus.stall_cycles = stall_cycles_q;
   assign bus.flush_count  = flush_count_q;
`endif

endmodule
